// File: rtl/rd_burst_ctrl.sv
// rd_burst_ctrl: read-side burst controller for a single-clock FIFO.
// It tracks occupancy from the write and pop strobes. A burst is armed when the
// fill threshold is reached or when full is asserted. The controller then presents
// rd_valid with a ready handshake until the entries present at burst start have
// been popped.
// Optional feature: define RD_BURST_TIMEOUT_EN to enable the partial-flush timeout.
// When it is enabled, partial data that has sat idle for TIMEOUT_CYCLES cycles is
// flushed.
//
// state | meaning
// IDLE  | waiting for threshold / full (/ timeout) with non-empty FIFO
// BURST | presenting rd_valid, counting pops against the length latched at start
// DONE  | single cycle, burst_done pulse, rd_valid low
module rd_burst_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int COUNTER_WIDTH  = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5
) (
  input  logic                     rd_clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     full,
  input  logic                     rd_ready,
  input  logic [COUNTER_WIDTH:0]   thresh,
  output logic                     rd_valid,
  output logic                     rd_en,
  output logic [COUNTER_WIDTH:0]   level,
  output logic                     burst_active,
  output logic                     burst_done
);

  localparam int CW = COUNTER_WIDTH + 1;
  localparam logic [COUNTER_WIDTH:0] DEPTH   = CW'(FIFO_DEPTH);
  localparam logic [COUNTER_WIDTH:0] CNT_ONE = CW'(1);

  if (FIFO_DEPTH < 1 || FIFO_DEPTH > (1 << COUNTER_WIDTH)) begin : g_bad_depth
    $error("rd_burst_ctrl: FIFO_DEPTH does not fit COUNTER_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TIMEOUT_WIDTH)) begin : g_bad_tmo
    $error("rd_burst_ctrl: TIMEOUT_CYCLES does not fit TIMEOUT_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNTER_WIDTH:0] burst_cnt;
  logic [COUNTER_WIDTH:0] burst_len;
  logic [COUNTER_WIDTH:0] eff_thr;
  logic [COUNTER_WIDTH:0] level_nxt;
  logic                   level_inc;
  logic                   thr_hit;
  logic                   tmo_fire;
  logic                   start;

  // Out-of-range thresholds fall back to "wait until the FIFO is full".
  always_comb begin
    eff_thr = thresh;
    if (thresh == '0 || thresh > DEPTH) eff_thr = DEPTH;
  end

  assign thr_hit = (level != '0) && ((level >= eff_thr) || full);

`ifdef RD_BURST_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic                     tmo_run;

  assign tmo_run  = (state == IDLE) && (level != '0) && (level < eff_thr) && !full;
  assign tmo_fire = tmo_run && (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Idle-age counter for partial data. Any write restarts the wait.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (!tmo_run || wr_en || tmo_fire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  assign start = (state == IDLE) && (thr_hit || tmo_fire);

  // Writes at full capacity are dropped. A simultaneous write and pop cancel out.
  assign level_inc = wr_en && (level < DEPTH);

  always_comb begin
    level_nxt = level;
    case ({level_inc, rd_en})
      2'b10:   level_nxt = level + CNT_ONE;
      2'b01:   level_nxt = level - CNT_ONE;
      default: level_nxt = level;
    endcase
  end

  // State register, occupancy, and burst bookkeeping.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state     <= IDLE;
      level     <= '0;
      burst_cnt <= '0;
      burst_len <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      if (start) begin
        burst_len <= level;
        burst_cnt <= '0;
      end else if (rd_en) begin
        burst_cnt <= burst_cnt + CNT_ONE;
      end
    end
  end

  // Next-state and handshake decode. burst_len is frozen, so later writes cannot extend a burst.
  always_comb begin
    state_nxt = state;
    rd_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = BURST;
      end
      BURST: begin
        rd_valid = (level != '0);
        if (rd_valid && rd_ready && (burst_cnt == burst_len - CNT_ONE)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rd_en        = rd_valid & rd_ready;
  assign burst_active = (state == BURST);
  assign burst_done   = (state == DONE);

endmodule

// File: tb/tb_rd_burst_ctrl.sv
// tb_rd_burst_ctrl: directed scenarios followed by random traffic.
// All traffic is compared cycle by cycle against an occupancy/burst model.
module tb_rd_burst_ctrl;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic       rd_clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       full;
  logic       rd_ready;
  logic [3:0] thresh;
  logic       rd_valid;
  logic       rd_en;
  logic [3:0] level;
  logic       burst_active;
  logic       burst_done;

  rd_burst_ctrl #(
    .FIFO_DEPTH    (DEPTH),
    .COUNTER_WIDTH (3),
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_WIDTH (5)
  ) dut (
    .rd_clk      (rd_clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .full        (full),
    .rd_ready    (rd_ready),
    .thresh      (thresh),
    .rd_valid    (rd_valid),
    .rd_en       (rd_en),
    .level       (level),
    .burst_active(burst_active),
    .burst_done  (burst_done)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: occupancy, entries still owed by the current burst, done-cycle flag,
  // and the age of the partial data.
  int m_level;
  int m_left;
  int m_age;
  bit m_burst;
  bit m_done;

  int seen_en;
  int seen_done;
  int seen_valid;
  bit obs_valid;
  bit obs_done;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_level = 0;
    m_left  = 0;
    m_age   = 0;
    m_burst = 0;
    m_done  = 0;
  endtask

  task automatic clear_seen();
    seen_en    = 0;
    seen_done  = 0;
    seen_valid = 0;
  endtask

  task automatic model_update(input bit w, input bit rdy, input bit fl, input int thr, input bit rst);
    int eff;
    bit inc;
    bit pop;
    bit fire;
    if (rst) begin
      model_clear();
      return;
    end
    eff  = (thr == 0 || thr > DEPTH) ? DEPTH : thr;
    inc  = w && (m_level < DEPTH);
    pop  = m_burst && (m_level != 0) && rdy;
    fire = 0;
`ifdef RD_BURST_TIMEOUT_EN
    if (!m_burst && !m_done && m_level > 0 && m_level < eff && !fl) begin
      if (m_age == TMO - 1) begin
        fire  = 1;
        m_age = 0;
      end else if (w) begin
        m_age = 0;
      end else begin
        m_age++;
      end
    end else begin
      m_age = 0;
    end
`endif
    if (m_done) begin
      m_done = 0;
    end else if (m_burst) begin
      if (pop) begin
        m_left--;
        if (m_left == 0) begin
          m_burst = 0;
          m_done  = 1;
        end
      end
    end else if (m_level != 0 && (m_level >= eff || fl || fire)) begin
      m_burst = 1;
      m_left  = m_level;
    end
    m_level = m_level + int'(inc) - int'(pop);
  endtask

  // One clock cycle. Drive the inputs, compare the outputs at the falling edge,
  // then advance the model on the rising edge.
  task automatic cyc(input bit w, input bit rdy, input bit fl, input int thr, input bit rst);
    int exp_valid;
    wr_en    = w;
    rd_ready = rdy;
    full     = fl;
    thresh   = 4'(thr);
    reset    = rst;
    @(negedge rd_clk);
    exp_valid = (m_burst && m_level != 0) ? 1 : 0;
    check_val("rd_valid", int'(rd_valid), exp_valid);
    check_val("rd_en", int'(rd_en), exp_valid & int'(rdy));
    check_val("level", int'(level), m_level);
    check_val("burst_active", int'(burst_active), int'(m_burst));
    check_val("burst_done", int'(burst_done), int'(m_done));
    obs_valid  = rd_valid;
    obs_done   = burst_done;
    seen_en    += int'(rd_en);
    seen_done  += int'(burst_done);
    seen_valid += int'(rd_valid);
    @(posedge rd_clk);
    model_update(w, rdy, fl, thr, rst);
    #1;
  endtask

  initial begin
    int done_at;
    int first_valid;

    wr_en    = 0;
    full     = 0;
    rd_ready = 0;
    thresh   = 4'd4;
    reset    = 1;
    repeat (2) @(posedge rd_clk);
    #1;
    model_clear();
    clear_seen();
    check_val("reset_level", int'(level), 0);
    check_val("reset_valid", int'(rd_valid), 0);
    check_val("reset_active", int'(burst_active), 0);
    check_val("reset_done", int'(burst_done), 0);

    // Test 1: threshold 4 with the consumer always ready.
    clear_seen();
    repeat (4) cyc(1, 1, 0, 4, 0);
    repeat (12) cyc(0, 1, 0, 4, 0);
    check_val("t1_rd_en_count", seen_en, 4);
    check_val("t1_done_count", seen_done, 1);
    check_val("t1_level_end", int'(level), 0);

    // Test 2: threshold 0 means wait for 8 entries. The 9th write at level 8 is dropped.
    clear_seen();
    repeat (8) cyc(1, 1, 0, 0, 0);
    check_val("t2_no_early_valid", seen_valid, 0);
    cyc(1, 1, 0, 0, 0);
    check_val("t2_level_sat", int'(level), 8);
    repeat (14) cyc(0, 1, 0, 0, 0);
    check_val("t2_rd_en_count", seen_en, 8);
    check_val("t2_level_end", int'(level), 0);

    // Test 3: backpressure. With ready toggling, done lands on the 8th cycle of the burst.
    repeat (4) cyc(1, 0, 0, 4, 0);
    cyc(0, 0, 0, 4, 0);
    clear_seen();
    done_at = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(0, (i % 2) == 0, 0, 4, 0);
      if (obs_done && done_at < 0) done_at = i;
    end
    check_val("t3_rd_en_count", seen_en, 4);
    check_val("t3_valid_cycles", seen_valid, 7);
    check_val("t3_done_cycle", done_at, 7);

    // Test 4: writes during a burst do not extend it. A second burst of 3 follows.
    clear_seen();
    repeat (2) cyc(1, 1, 0, 2, 0);
    repeat (3) cyc(1, 1, 0, 2, 0);
    repeat (12) cyc(0, 1, 0, 2, 0);
    check_val("t4_done_count", seen_done, 2);
    check_val("t4_rd_en_count", seen_en, 5);
    check_val("t4_level_end", int'(level), 0);

    // Test 5: a reset in the middle of a burst aborts it without a done pulse.
    clear_seen();
    repeat (5) cyc(1, 1, 0, 5, 0);
    repeat (3) cyc(0, 1, 0, 5, 0);
    check_val("t5_reads_before_rst", seen_en, 2);
    cyc(0, 0, 0, 5, 1);
    check_val("t5_level_after_rst", int'(level), 0);
    check_val("t5_valid_after_rst", int'(rd_valid), 0);
    check_val("t5_active_after_rst", int'(burst_active), 0);
    repeat (4) cyc(0, 1, 0, 5, 0);
    check_val("t5_no_done", seen_done, 0);

    // Test 6: partial data below the threshold.
    repeat (3) cyc(1, 1, 0, 8, 0);
    clear_seen();
    first_valid = -1;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1, 0, 8, 0);
      if (obs_valid && first_valid < 0) first_valid = i;
    end
`ifdef RD_BURST_TIMEOUT_EN
    check_val("t6_flush_start", first_valid, 16);
    check_val("t6_rd_en_count", seen_en, 3);
    check_val("t6_level_end", int'(level), 0);
`else
    check_val("t6_no_valid", seen_valid, 0);
    check_val("t6_level_held", int'(level), 3);
`endif
    cyc(0, 0, 0, 8, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(1, 0) == 1,
          $urandom_range(3, 0) != 0,
          $urandom_range(15, 0) == 0,
          int'($urandom_range(15, 0)),
          $urandom_range(299, 0) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
